// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential 32x32 signed radix-2 Booth multiplier, one ripple add per cycle
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH:0]   acc, mx, neg_mx, add_a, add_b, sum, acc_sh;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] qr, qr_sh;
  logic             q_1;
  logic [5:0]       count;
  // In IDLE the same adder forms ~Mx + 1 so negMx is ready before the first step
  always_comb begin
    add_a = (state == IDLE) ? ~{multiplicand[WIDTH-1], multiplicand} : acc;
    add_b = (state != RUN) ? '0 :
            ({qr[0], q_1} == 2'b01) ? mx :
            ({qr[0], q_1} == 2'b10) ? neg_mx : '0;
  end
  assign c[0] = (state == IDLE);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_rca
      fulladder u_fa (.a(add_a[i]), .b(add_b[i]), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
    end
  endgenerate
  // Top bit needs no carry-out; it is discarded in 33-bit two's complement
  assign sum[WIDTH] = add_a[WIDTH] ^ add_b[WIDTH] ^ c[WIDTH];
  assign acc_sh     = {sum[WIDTH], sum[WIDTH:1]};
  assign qr_sh      = {sum[0], qr[WIDTH-1:1]};
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN)  ? ((count == 6'd31) ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      qr     <= '0;
      q_1    <= 1'b0;
      mx     <= '0;
      neg_mx <= '0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      qr     <= multiplier;
      q_1    <= 1'b0;
      mx     <= {multiplicand[WIDTH-1], multiplicand};
      neg_mx <= sum;
      count  <= '0;
    end else if (state == RUN) begin
      acc   <= acc_sh;
      qr    <= qr_sh;
      q_1   <= qr[0];
      count <= count + 6'd1;
      if (count == 6'd31) begin
        hi <= acc_sh[WIDTH-1:0];
        lo <= qr_sh;
      end
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed and regression checks for booth_multiplier
module tb_booth_multiplier;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int checks = 0;
  int errors = 0;

  booth_multiplier #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Start at E0, scramble operands during RUN, stop one edge after done (back in IDLE)
  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        output logic [63:0] p, output int lat, output logic busy_after);
    @(negedge clock);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      multiplicand = $urandom; multiplier = $urandom;
      @(posedge clock); #1;
      lat++;
    end
    p = {hi, lo};
    @(posedge clock); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_product got %h want 0", {hi, lo}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [63:0] p; int lat; logic ba;
    run_op(32'h00000006, 32'h00000007, p, lat, ba);
    checks++; if (lat !== 32) begin errors++; $display("FAIL latency_6x7 got %0d edges want 32", lat); end
    checks++; if (p !== 64'h00000000_0000002A) begin errors++; $display("FAIL prod_6x7 got %h want 000000000000002a", p); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL busy_after_6x7 got %b want 0", ba); end
    run_op(32'hFFFFFFFD, 32'h00000005, p, lat, ba);
    checks++; if (p !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL prod_m3x5 got %h want fffffffffffffff1", p); end
  endtask

  task automatic test_extremes;
    logic [31:0] ms [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] qs [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] ps [3] = '{64'h40000000_00000000, 64'h00000000_00000001, 64'hC0000000_80000000};
    logic [63:0] p; int lat; logic ba;
    for (int k = 0; k < 3; k++) begin
      run_op(ms[k], qs[k], p, lat, ba);
      checks++;
      if (p !== ps[k]) begin errors++; $display("FAIL extreme_%0d got %h want %h", k, p, ps[k]); end
    end
  endtask

  task automatic test_start_while_busy;
    int ndone = 0;
    logic [31:0] lo_at_done = '0;
    logic [63:0] p; int lat; logic ba;
    @(negedge clock);
    start = 1'b1; multiplicand = 32'd2; multiplier = 32'd3;
    @(posedge clock); #1;
    start = 1'b0; multiplicand = 32'd9; multiplier = 32'd9;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clock); #1;
      if (done) begin ndone++; lo_at_done = lo; end
      start = (k == 4 || k == 31 || k == 32);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
    checks++; if (lo_at_done !== 32'd6) begin errors++; $display("FAIL busy_start_lo got %0d want 6", lo_at_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got busy=%b want 0", busy); end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    p = {hi, lo};
    checks++; if (p !== 64'd81) begin errors++; $display("FAIL e34_start got %h want 81 (lat %0d)", p, lat); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    logic [63:0] p; int lat; logic ba;
    @(negedge clock);
    start = 1'b1; multiplicand = 32'h12345678; multiplier = 32'h9ABCDEF0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL midreset_product got %h want 0", {hi, lo}); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin @(posedge clock); #1; if (done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", ndone); end
    run_op(32'h12345678, 32'h9ABCDEF0, p, lat, ba);
    checks++; if (p !== 64'hF8CC93D6_242D2080) begin errors++; $display("FAIL rerun_prod got %h want f8cc93d6242d2080", p); end
  endtask

  task automatic test_random;
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
    logic [31:0] m, q;
    logic [63:0] p, expv; int lat; logic ba;
    for (int k = 0; k < 1000; k++) begin
      if (k < 36) begin m = corners[k / 6]; q = corners[k % 6]; end
      else begin
        m = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
        q = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      end
      expv = 64'(longint'($signed(m)) * longint'($signed(q)));
      run_op(m, q, p, lat, ba);
      checks++;
      if (p !== expv || lat >= 40) begin
        errors++;
        $display("FAIL random_%0d %h*%h got %h want %h lat %0d", k, m, q, p, expv, lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_start_while_busy;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
